pe_stream_driver: RTL and testbench

Initiator side of the single-MAC PE interface. Accepts a valid/ready stream of (IFM, weight) pairs and drives one PE's IFM/Weight/PE_reset/PE_finish inputs. Brackets each window of cfg_len pairs with PE_reset on the first beat and PE_finish on the last. Captures the PE result on its valid pulse into a small result FIFO exposed as a valid/ready output stream.

---
 rtl/pe_drv_pkg.sv | 14 +
 rtl/pe_drv_res_fifo.sv | 52 +++++
 rtl/pe_stream_driver.sv | 142 ++++++++++++++
 tb/tb_pe_stream_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_drv_pkg.sv
// Shared types and default widths for the single-MAC PE stream driver.
package pe_drv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE,
        ACCUM
    } drv_state_t;

endpackage

// File: rtl/pe_drv_res_fifo.sv
// First-word fall-through result FIFO; push and pop in the same cycle are legal even when full.
module pe_drv_res_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_q, wr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CntW'(Depth));
    assign count_o    = cnt_q;
    assign pop_data_o = mem_q[rd_q];
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/pe_stream_driver.sv
// Drives one single-MAC PE from a pair stream, framing windows with PE_reset/PE_finish.
// Optional status outputs (err_unexp_valid, win_count) are built when PE_DRV_STATUS_EN is defined.
module pe_stream_driver
    import pe_drv_pkg::*;
#(
    parameter int unsigned DATA_W    = pe_drv_pkg::DATA_W,
    parameter int unsigned CNT_W     = pe_drv_pkg::CNT_W,
    parameter int unsigned RES_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_ifm,
    input  logic [DATA_W-1:0] s_weight,
    output logic [DATA_W-1:0] pe_ifm,
    output logic [DATA_W-1:0] pe_weight,
    output logic              pe_reset,
    output logic              pe_finish,
    input  logic [DATA_W-1:0] pe_ofm,
    input  logic              pe_valid,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_ofm
`ifdef PE_DRV_STATUS_EN
    ,
    output logic              err_unexp_valid,
    output logic [15:0]       win_count
`endif
);

    localparam int unsigned OccW = $clog2(RES_DEPTH + 1);

    drv_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q, len_q;
    logic [DATA_W-1:0] pe_ifm_q, pe_weight_q;
    logic              pe_reset_q, pe_finish_q;
    logic [OccW-1:0]   inflight_q;

    logic [OccW-1:0]   fifo_cnt;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full, fifo_empty;
    logic              first_beat, last_beat, accept, pop, push;
    logic [OccW:0]     occupied, limit;

    assign first_beat = (state_q == IDLE);
    assign last_beat  = first_beat ? (cfg_len <= CNT_W'(1)) : (cnt_q == len_q - CNT_W'(1));

    // A pop in the same cycle frees a slot for the window being closed.
    assign pop      = m_valid && m_ready;
    assign occupied = {1'b0, fifo_cnt} + {1'b0, inflight_q};
    assign limit    = (OccW + 1)'(RES_DEPTH) + (OccW + 1)'(pop);
    assign s_ready  = reset_n && (!last_beat || (occupied < limit));
    assign accept   = s_valid && s_ready;
    assign push     = pe_valid && (inflight_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            pe_ifm_q    <= '0;
            pe_weight_q <= '0;
            pe_reset_q  <= 1'b0;
            pe_finish_q <= 1'b0;
        end else begin
            // Bubbles feed zero products so the PE accumulator holds its value.
            pe_ifm_q    <= '0;
            pe_weight_q <= '0;
            pe_reset_q  <= 1'b0;
            pe_finish_q <= 1'b0;
            if (accept) begin
                pe_ifm_q    <= s_ifm;
                pe_weight_q <= s_weight;
                pe_reset_q  <= first_beat;
                pe_finish_q <= last_beat;
                if (first_beat) len_q <= (cfg_len == '0) ? CNT_W'(1) : cfg_len;
                if (last_beat) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= ACCUM;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q + OccW'(accept && last_beat) - OccW'(push);
        end
    end

    pe_drv_res_fifo #(
        .Depth (RES_DEPTH),
        .Width (DATA_W),
        .CntW  (OccW)
    ) u_res_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (pe_ofm),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .count_o     (fifo_cnt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pe_ifm    = pe_ifm_q;
    assign pe_weight = pe_weight_q;
    assign pe_reset  = pe_reset_q;
    assign pe_finish = pe_finish_q;
    assign m_valid   = !fifo_empty;
    assign m_ofm     = fifo_empty ? '0 : fifo_data;

`ifdef PE_DRV_STATUS_EN
    logic        err_q;
    logic [15:0] win_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
            win_q <= '0;
        end else begin
            if (pe_valid && inflight_q == '0) err_q <= 1'b1;
            if (push) win_q <= win_q + 16'd1;
        end
    end

    assign err_unexp_valid = err_q;
    assign win_count       = win_q;
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver attached to a behavioural single-MAC PE; a window-level model checks every cycle.
module tb_pe_stream_driver;

    localparam int Depth = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] cfg_len = 8'd1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_ifm = '0, s_weight = '0;
    logic [7:0] pe_ifm, pe_weight, pe_ofm;
    logic       pe_reset, pe_finish, pe_valid;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_ofm;
`ifdef PE_DRV_STATUS_EN
    logic        err_unexp_valid;
    logic [15:0] win_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_stream_driver #(.DATA_W(8), .CNT_W(8), .RES_DEPTH(Depth)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_len   (cfg_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_ifm     (s_ifm),
        .s_weight  (s_weight),
        .pe_ifm    (pe_ifm),
        .pe_weight (pe_weight),
        .pe_reset  (pe_reset),
        .pe_finish (pe_finish),
        .pe_ofm    (pe_ofm),
        .pe_valid  (pe_valid),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_ofm     (m_ofm)
`ifdef PE_DRV_STATUS_EN
        ,
        .err_unexp_valid (err_unexp_valid),
        .win_count       (win_count)
`endif
    );

    // Single-MAC PE: PE_reset restarts the sum, PE_finish emits it with a one-cycle valid pulse.
    logic [7:0] acc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0; pe_valid <= 1'b0; pe_ofm <= '0;
        end else begin
            logic [7:0] nxt;
            nxt = (pe_reset ? 8'd0 : acc) + pe_ifm * pe_weight;
            acc <= nxt;
            pe_valid <= pe_finish;
            if (pe_finish) pe_ofm <= nxt;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window-level model: results in acceptance order, each visible 3 cycles after its last beat.
    int   exp_val[$];
    int   exp_at[$];
    int   lit_q[$];
    int   cyc = 0;
    int   pos = 0, wlen = 1, sum = 0;
    int   e_ifm = 0, e_wgt = 0, e_rst = 0, e_fin = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_pe_ifm", pe_ifm, 0);
            chk("rst_pe_weight", pe_weight, 0);
            chk("rst_pe_reset", pe_reset, 0);
            chk("rst_pe_finish", pe_finish, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_ofm", m_ofm, 0);
            exp_val.delete(); exp_at.delete();
            pos = 0; sum = 0; e_ifm = 0; e_wgt = 0; e_rst = 0; e_fin = 0;
        end else begin
            bit mv_exp, pop, last;
            int cfg;
            chk("pe_ifm", pe_ifm, e_ifm);
            chk("pe_weight", pe_weight, e_wgt);
            chk("pe_reset", pe_reset, e_rst);
            chk("pe_finish", pe_finish, e_fin);
            mv_exp = (exp_at.size() > 0) && (exp_at[0] <= cyc);
            chk("m_valid", m_valid, mv_exp);
            pop = mv_exp && m_ready;
            if (mv_exp) chk("m_ofm", m_ofm, exp_val[0]);
            if (pop) begin
                if (lit_q.size() > 0) chk("model_vs_hand", exp_val[0], lit_q.pop_front());
                void'(exp_val.pop_front()); void'(exp_at.pop_front());
            end
            cfg  = (cfg_len == 0) ? 1 : int'(cfg_len);
            last = (pos == 0) ? (cfg == 1) : (pos == wlen - 1);
            chk("s_ready", s_ready, (!last || (exp_val.size() < Depth)) ? 1 : 0);
            if (s_valid && s_ready) begin
                if (pos == 0) begin wlen = cfg; sum = 0; end
                sum += s_ifm * s_weight;
                e_ifm = s_ifm; e_wgt = s_weight; e_rst = (pos == 0); e_fin = last;
                if (last) begin
                    exp_val.push_back(sum % 256); exp_at.push_back(cyc + 3); pos = 0;
                end else pos++;
            end else begin
                e_ifm = 0; e_wgt = 0; e_rst = 0; e_fin = 0;
            end
        end
        cyc++;
    end

    task automatic send(input int a, input int b);
        int n = 0;
        s_valid = 1'b1; s_ifm = 8'(a); s_weight = 8'(b);
        @(negedge clk);
        while (!s_ready && n < 60) begin @(negedge clk); n++; end
        if (!s_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_val.size() > 0 && n < 60) begin @(posedge clk); #1; n++; end
        chk("drain_done", exp_val.size(), 0);
    endtask

    initial begin
        int k;
        #2 reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // Three-beat window, then count cycles to m_valid.
        cfg_len = 8'd3; lit_q.push_back(33);
        send(2, 3); send(4, 5); send(1, 7);
        k = 0;
        while (!m_valid && k < 10) begin @(negedge clk); k++; end
        chk("latency_t1", k, 3);
        drain();

        // Single-beat windows back to back.
        cfg_len = 8'd1; lit_q.push_back(100); lit_q.push_back(12);
        send(10, 10); send(3, 4);
        drain();

        // Wraparound: 256 + 16.
        cfg_len = 8'd2; lit_q.push_back(16);
        send(16, 16); send(16, 1);
        drain();

        // Gaps between beats give zero bubbles on the PE side.
        cfg_len = 8'd3; lit_q.push_back(33);
        send(2, 3); idle(2); send(4, 5); idle(2); send(1, 7);
        drain();

        // Backpressure: two credits only.
        cfg_len = 8'd1; m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) lit_q.push_back(i);
        fork
            begin
                for (int i = 1; i <= 5; i++) send(i, 1);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_s_ready_low", s_ready, 0);
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-window discards the partial window.
        cfg_len = 8'd3;
        send(1, 1); send(1, 1);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        lit_q.push_back(3);
        send(1, 1); send(1, 1); send(1, 1);
        drain();
        idle(3);
        chk("no_stale_m_valid", m_valid, 0);
        chk("hand_list_used", lit_q.size(), 0);
`ifdef PE_DRV_STATUS_EN
        chk("err_unexp_valid", err_unexp_valid, 0);
        chk("win_count", win_count, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
